// File: rtl/hd44780_pkg.sv
// Shared constants and state encoding for the HD44780 text buffer.
// Row bases follow the HD44780 DDRAM map for 1..4 line panels.
package hd44780_pkg;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [6:0] ROW_BASE [4]  = '{7'h00, 7'h40, 7'h14, 7'h54};

  // IDLE: pick lowest dirty row | ADDR: address command out | CHAR: row characters out
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CHAR = 2'd2
  } state_t;

  function automatic logic [7:0] ddram_cmd(input logic [1:0] row);
    return CMD_SET_DDRAM | {1'b0, ROW_BASE[row]};
  endfunction

endpackage

// File: rtl/hd44780_textbuf_mem.sv
// ROWS x COLS character store: one write port, combinational read mux.
// Out-of-range reads return BLANK; writes are pre-qualified by the caller.
module hd44780_textbuf_mem
  import hd44780_pkg::*;
#(
  parameter int          COLS  = 16,
  parameter int          ROWS  = 2,
  parameter logic [7:0]  BLANK = CHAR_SPACE,
  parameter int          RW    = 1,
  parameter int          CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_data,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [7:0]    rd_data
);

  logic [7:0] cells [ROWS][COLS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells[r][c] <= BLANK;
        end
      end
    end else if (we) begin
      cells[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    rd_data = BLANK;
    if ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) begin
      rd_data = cells[rd_row][rd_col];
    end
  end

endmodule

// File: rtl/hd44780_textbuf.sv
// Host-writable LCD text buffer that streams dirty rows to an HD44780 bus
// controller as a Set-DDRAM-address command followed by COLS data bytes.
module hd44780_textbuf
  import hd44780_pkg::*;
#(
  parameter int          COLS  = 16,
  parameter int          ROWS  = 2,
  parameter logic [7:0]  BLANK = CHAR_SPACE,
  localparam int         RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_data,
  input  logic          refresh,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_rs,
  output logic [7:0]    out_data,
  output logic          busy
);

  state_t            state_q, state_d;
  logic [ROWS-1:0]   dirty_q, dirty_d;
  logic [ROWS-1:0]   clr, wr_mask;
  logic [RW-1:0]     row_q, row_d, pick_row;
  logic [CW-1:0]     col_q, col_d, col_next, rd_col;
  logic              pick_found, wr_ok, last_col;
  logic              valid_d, rs_d;
  logic [7:0]        data_d, rd_data;

  assign wr_ok    = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign col_next = col_q + CW'(1);
  assign last_col = (int'(col_q) == COLS - 1);
  assign rd_col   = (state_q == ST_CHAR) ? col_next : '0;
  assign busy     = (state_q != ST_IDLE);

  hd44780_textbuf_mem #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .BLANK (BLANK),
    .RW    (RW),
    .CW    (CW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_ok),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (row_q),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  // Lowest-index dirty row wins.
  always_comb begin
    pick_found = 1'b0;
    pick_row   = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (dirty_q[i]) begin
        pick_found = 1'b1;
        pick_row   = RW'(i);
      end
    end
  end

  always_comb begin
    wr_mask = '0;
    if (wr_ok) wr_mask[wr_row] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = out_valid;
    rs_d    = out_rs;
    data_d  = out_data;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          row_d         = pick_row;
          clr[pick_row] = 1'b1;
          rs_d          = 1'b0;
          data_d        = ddram_cmd(2'(pick_row));
          valid_d       = 1'b1;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (out_ready) begin
          rs_d    = 1'b1;
          data_d  = rd_data;
          col_d   = '0;
          state_d = ST_CHAR;
        end
      end
      ST_CHAR: begin
        if (out_ready) begin
          if (last_col) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            col_d  = col_next;
            data_d = rd_data;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // No cell of the picked row has been read yet, so a write on the pick
    // edge is already covered; later writes to the streaming row re-dirty it.
    dirty_d = ((dirty_q | wr_mask) & ~clr) | {ROWS{refresh}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dirty_q   <= '1;
      row_q     <= '0;
      col_q     <= '0;
      out_valid <= 1'b0;
      out_rs    <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      dirty_q   <= dirty_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_valid <= valid_d;
      out_rs    <= rs_d;
      out_data  <= data_d;
    end
  end

endmodule

// File: tb/tb_hd44780_textbuf.sv
// Bench for hd44780_textbuf: a 16x2 instance for directed stream checks and
// a 10x3 instance driven randomly and checked through a virtual LCD DDRAM.
module tb_hd44780_textbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, wr_en1, refresh1, rdy1, v1, rs1, busy1;
  logic [0:0] wr_row1;
  logic [3:0] wr_col1;
  logic [7:0] wr_data1, d1;

  logic       rst2, wr_en2, refresh2, rdy2, v2, rs2, busy2;
  logic [1:0] wr_row2;
  logic [3:0] wr_col2;
  logic [7:0] wr_data2, d2;

  hd44780_textbuf #(.COLS(16), .ROWS(2)) u_dut (
    .clk(clk), .rst(rst1), .wr_en(wr_en1), .wr_row(wr_row1), .wr_col(wr_col1),
    .wr_data(wr_data1), .refresh(refresh1), .out_valid(v1), .out_ready(rdy1),
    .out_rs(rs1), .out_data(d1), .busy(busy1));

  hd44780_textbuf #(.COLS(10), .ROWS(3)) u_dut2 (
    .clk(clk), .rst(rst2), .wr_en(wr_en2), .wr_row(wr_row2), .wr_col(wr_col2),
    .wr_data(wr_data2), .refresh(refresh2), .out_valid(v2), .out_ready(rdy2),
    .out_rs(rs2), .out_data(d2), .busy(busy2));

  int tests = 0;
  int fails = 0;
  int BASE [4] = '{'h00, 'h40, 'h14, 'h54};

  logic [8:0] q1 [$];
  logic [8:0] q2 [$];
  logic [8:0] exp1 [$];
  logic [7:0] m1 [2][16];
  logic [7:0] m2 [3][10];
  logic [7:0] ddram [128];
  int cursor = 0;
  int left = 0;

  // A byte seen valid&ready here is accepted on the following rising edge.
  always @(negedge clk) begin
    if (!rst1 && v1 && rdy1) q1.push_back({rs1, d1});
    if (!rst2 && v2 && rdy2) q2.push_back({rs2, d2});
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input int r, input int c, input logic [7:0] d);
    wr_en1 = 1'b1; wr_row1 = 1'(r); wr_col1 = 4'(c); wr_data1 = d;
    if (r < 2 && c < 16) m1[r][c] = d;
    step();
    wr_en1 = 1'b0;
  endtask

  task automatic wr2(input int r, input int c, input logic [7:0] d);
    wr_en2 = 1'b1; wr_row2 = 2'(r); wr_col2 = 4'(c); wr_data2 = d;
    if (r < 3 && c < 10) m2[r][c] = d;
    step();
    wr_en2 = 1'b0;
  endtask

  task automatic expect_row1(input int r);
    exp1.push_back({1'b0, 8'h80 | 8'(BASE[r])});
    for (int c = 0; c < 16; c++) exp1.push_back({1'b1, m1[r][c]});
  endtask

  task automatic wait_quiet(input int inst, input string tag);
    int idle = 0;
    int cyc = 0;
    while (idle < 3 && cyc < 3000) begin
      step();
      cyc++;
      if (inst == 1) idle = (!busy1 && !v1) ? idle + 1 : 0;
      else           idle = (!busy2 && !v2) ? idle + 1 : 0;
    end
    check({tag, "_quiet"}, (idle >= 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_size1(input int n, input string tag);
    int cyc = 0;
    while (q1.size() < n && cyc < 500) begin
      step();
      cyc++;
    end
    check({tag, "_reach"}, q1.size(), n);
  endtask

  task automatic cmp_q1(input string tag);
    int n;
    check({tag, "_len"}, q1.size(), exp1.size());
    n = (q1.size() < exp1.size()) ? q1.size() : exp1.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), q1[i], exp1[i]);
    q1.delete();
    exp1.delete();
  endtask

  // Replays captured bytes into a virtual DDRAM and checks burst framing.
  task automatic lcd_apply2(input string tag);
    logic [8:0] e;
    while (q2.size() > 0) begin
      e = q2.pop_front();
      if (!e[8]) begin
        check({tag, "_burst_len"}, left, 0);
        check({tag, "_cmd_bit"}, e[7], 1);
        cursor = int'(e[6:0]);
        left = 10;
      end else begin
        ddram[cursor] = e[7:0];
        cursor = (cursor + 1) % 128;
        left--;
      end
    end
    check({tag, "_burst_end"}, left, 0);
  endtask

  task automatic cmp_lcd2(input string tag);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 10; c++)
        check($sformatf("%s_r%0dc%0d", tag, r, c), ddram[BASE[r] + c], m2[r][c]);
  endtask

  initial begin
    logic [7:0] held_d;
    logic       held_rs;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 16; c++) m1[r][c] = 8'h20;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 10; c++) m2[r][c] = 8'h20;
    for (int i = 0; i < 128; i++) ddram[i] = 8'h00;
    rst1 = 1'b1; wr_en1 = 1'b0; refresh1 = 1'b0; rdy1 = 1'b1;
    wr_row1 = '0; wr_col1 = '0; wr_data1 = '0;
    rst2 = 1'b1; wr_en2 = 1'b0; refresh2 = 1'b0; rdy2 = 1'b1;
    wr_row2 = '0; wr_col2 = '0; wr_data2 = '0;
    step();
    step();
    check("rst_valid", v1, 0);
    check("rst_rs", rs1, 0);
    check("rst_data", d1, 0);
    check("rst_busy", busy1, 0);

    // 1: power-up redraw of both blank rows
    rst1 = 1'b0; rst2 = 1'b0;
    expect_row1(0); expect_row1(1);
    wait_quiet(1, "t1");
    check("t1_busy", busy1, 0);
    cmp_q1("t1");

    // 2: two writes to row 1 give one burst, command one idle cycle later
    wr1(1, 0, "H");
    check("t2_lat_idle", v1, 0);
    wr1(1, 1, "i");
    check("t2_lat_valid", v1, 1);
    check("t2_lat_cmd", {rs1, d1}, {1'b0, 8'hC0});
    expect_row1(1);
    wait_quiet(1, "t2");
    cmp_q1("t2");

    // 3: five-cycle stall mid-row holds the output byte
    wr1(1, 5, "#");
    expect_row1(1);
    wait_size1(6, "t3");
    rdy1 = 1'b0;
    held_d = d1; held_rs = rs1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t3_stall_v%0d", i), v1, 1);
      check($sformatf("t3_stall_d%0d", i), {rs1, d1}, {held_rs, held_d});
    end
    rdy1 = 1'b1;
    wait_quiet(1, "t3");
    cmp_q1("t3");

    // 4: write to already-sent cell of the streaming row forces a resend
    wr1(0, 15, "Z");
    expect_row1(0);
    wait_size1(11, "t4");
    wr1(0, 3, "X");
    expect_row1(0);
    wait_quiet(1, "t4");
    cmp_q1("t4");

    // 5: refresh redraws every row
    refresh1 = 1'b1; step(); refresh1 = 1'b0;
    expect_row1(0); expect_row1(1);
    wait_quiet(1, "t5");
    cmp_q1("t5");

    // 6: reset during row 1 drops valid at once, then blank redraw
    refresh1 = 1'b1; step(); refresh1 = 1'b0;
    wait_size1(23, "t6");
    check("t6_pre_busy", busy1, 1);
    rst1 = 1'b1;
    #1;
    check("t6_rst_valid", v1, 0);
    check("t6_rst_busy", busy1, 0);
    check("t6_rst_data", d1, 0);
    q1.delete();
    exp1.delete();
    for (int r = 0; r < 2; r++) for (int c = 0; c < 16; c++) m1[r][c] = 8'h20;
    step();
    step();
    rst1 = 1'b0;
    expect_row1(0); expect_row1(1);
    wait_quiet(1, "t6");
    cmp_q1("t6");

    // Random writes, refreshes and back-pressure on the 10x3 instance
    for (int i = 0; i < 400; i++) begin
      wr_en2 = ($urandom_range(0, 1) == 1);
      wr_row2 = 2'($urandom_range(0, 3));
      wr_col2 = 4'($urandom_range(0, 15));
      wr_data2 = 8'($urandom);
      refresh2 = ($urandom_range(0, 31) == 0);
      rdy2 = ($urandom_range(0, 2) != 0);
      if (wr_en2 && int'(wr_row2) < 3 && int'(wr_col2) < 10) m2[wr_row2][wr_col2] = wr_data2;
      step();
    end
    wr_en2 = 1'b0; refresh2 = 1'b0; rdy2 = 1'b1;
    wait_quiet(2, "rnd");
    lcd_apply2("rnd");
    cmp_lcd2("rnd");

    // Out-of-range writes are dropped and start no burst
    wr2(3, 0, "Q");
    wr2(0, 10, "R");
    wr2(2, 15, "S");
    for (int i = 0; i < 10; i++) step();
    check("drop_no_burst", q2.size(), 0);
    check("drop_busy", busy2, 0);
    refresh2 = 1'b1; step(); refresh2 = 1'b0;
    wait_quiet(2, "drop");
    lcd_apply2("drop");
    cmp_lcd2("drop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
